run_controller: RTL

Run/step controller at the top of the CPU build, between the 50 MHz board clock and the processor core. Generates a divided step-enable tick instead of a derived clock, gates core execution in free-run or single-step mode, and counts executed steps. Captures a selectable byte lane of the core output word and raises a sticky end flag when the core emits a programmable sentinel value, with an optional step-count timeout.

---
 rtl/run_controller_if.sv | 35 +++
 rtl/run_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/run_controller_if.sv
// Run/step controller bundle: control inputs, core output capture and status.
// The slave modport is the controller side, the master modport the board/core side.
interface run_controller_if #(
    parameter int WIDTH = 36,
    parameter int OUTW  = 8,
    parameter int CNTW  = 32
);
    localparam int NLANES = (WIDTH + OUTW - 1) / OUTW;
    localparam int LSW    = (NLANES <= 1) ? 1 : $clog2(NLANES);

    logic             startIO;
    logic             stepMode;
    logic             stepReq;
    logic [WIDTH-1:0] coreOut;
    logic             coreOutValid;
    logic [LSW-1:0]   laneSel;
    logic             coreEn;
    logic             tick;
    logic [OUTW-1:0]  out;
    logic             outFlag;
    logic             endFlag;
    logic             timeoutFlag;
    logic [CNTW-1:0]  stepCount;
    logic             busy;

    modport master (
        output startIO, stepMode, stepReq, coreOut, coreOutValid, laneSel,
        input  coreEn, tick, out, outFlag, endFlag, timeoutFlag, stepCount, busy
    );

    modport slave (
        input  startIO, stepMode, stepReq, coreOut, coreOutValid, laneSel,
        output coreEn, tick, out, outFlag, endFlag, timeoutFlag, stepCount, busy
    );
endinterface

// File: rtl/run_controller.sv
// Run/step controller: tick divider, free-run/single-step gating, step counter,
// output lane capture and sentinel detection. Optional timeout: RUNCTRL_TIMEOUT_EN.
module run_controller #(
    parameter int WIDTH     = 36,
    parameter int OUTW      = 8,
    parameter int DIV       = 50000000,
    parameter int END_VALUE = 500,
    parameter int CNTW      = 32,
    parameter int MAXSTEPS  = 0
) (
    input logic            clock,
    input logic            reset,
    run_controller_if.slave bus
);
    localparam int NLANES = (WIDTH + OUTW - 1) / OUTW;
    localparam int LSW    = (NLANES <= 1) ? 1 : $clog2(NLANES);
    localparam int PADW   = NLANES * OUTW;
    localparam int DIVW   = (DIV <= 1) ? 1 : $clog2(DIV);

    localparam logic [DIVW-1:0]  DIV_LAST = DIVW'(DIV - 1);
    localparam logic [WIDTH-1:0] END_W    = WIDTH'(END_VALUE);
    localparam logic [CNTW-1:0]  CNT_MAX  = {CNTW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [DIVW-1:0]   div_cnt_r;
    logic              tick_s;
    logic              step_q_r;
    logic              step_pulse_r;
    logic              core_en_s;
    logic              active_s;
    logic              end_hit_s;
    logic              timeout_hit_s;
    logic [PADW-1:0]   padded_s;
    logic [OUTW-1:0]   lane_s;
    logic [CNTW-1:0]   step_next_s;
    logic [OUTW-1:0]   out_r;
    logic              out_flag_r;
    logic              end_flag_r;
    logic              timeout_flag_r;
    logic [CNTW-1:0]   step_count_r;

    // Free-running step divider, wraps after DIV-1 in every state.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_r <= {DIVW{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIVW{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIVW'(1);
        end
    end

    assign tick_s = (div_cnt_r == DIV_LAST);

    // Step request edge detector; a pulse is only armed while in STEP.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_q_r     <= 1'b0;
            step_pulse_r <= 1'b0;
        end else begin
            step_q_r     <= bus.stepReq;
            step_pulse_r <= (state_r == ST_STEP) && bus.stepReq && !step_q_r;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; stepMode only matters on the way out of IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.startIO) begin
                    state_s = bus.stepMode ? ST_STEP : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN, ST_STEP: begin
                if (end_hit_s || timeout_hit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: core enable per mode and the running indication.
    always_comb begin
        core_en_s = 1'b0;
        active_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                core_en_s = 1'b0;
                active_s  = 1'b0;
            end
            ST_RUN: begin
                core_en_s = tick_s;
                active_s  = 1'b1;
            end
            ST_STEP: begin
                core_en_s = step_pulse_r;
                active_s  = 1'b1;
            end
            ST_DONE: begin
                core_en_s = 1'b0;
                active_s  = 1'b0;
            end
            default: begin
                core_en_s = 1'b0;
                active_s  = 1'b0;
            end
        endcase
    end

    // Lane select over the zero-padded word; out-of-range selects give zero.
    always_comb begin
        padded_s                = {PADW{1'b0}};
        padded_s[WIDTH-1:0]     = bus.coreOut;
        lane_s                  = {OUTW{1'b0}};
        for (int i = 0; i < NLANES; i++) begin
            lane_s = (bus.laneSel == LSW'(i)) ? padded_s[i*OUTW +: OUTW] : lane_s;
        end
    end

    assign step_next_s = (step_count_r == CNT_MAX) ? step_count_r : step_count_r + CNTW'(1);
    assign end_hit_s   = bus.coreOutValid && (bus.coreOut == END_W);

`ifdef RUNCTRL_TIMEOUT_EN
    localparam logic [CNTW-1:0] MAX_W = CNTW'(MAXSTEPS);

    // Predict the limit on the enabling cycle so no further coreEn can slip out.
    always_comb begin
        if ((MAXSTEPS != 0) && core_en_s && (step_next_s == MAX_W)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Capture, step counting and sticky end/timeout flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_r          <= {OUTW{1'b0}};
            out_flag_r     <= 1'b0;
            end_flag_r     <= 1'b0;
            timeout_flag_r <= 1'b0;
            step_count_r   <= {CNTW{1'b0}};
        end else begin
            if (bus.coreOutValid && (state_r != ST_DONE)) begin
                out_r <= lane_s;
            end else begin
                out_r <= out_r;
            end
            out_flag_r <= bus.coreOutValid && (state_r != ST_DONE);
            if (core_en_s) begin
                step_count_r <= step_next_s;
            end else begin
                step_count_r <= step_count_r;
            end
            if (active_s && end_hit_s) begin
                end_flag_r <= 1'b1;
            end else begin
                end_flag_r <= end_flag_r;
            end
            if (active_s && timeout_hit_s && !end_hit_s) begin
                timeout_flag_r <= 1'b1;
            end else begin
                timeout_flag_r <= timeout_flag_r;
            end
        end
    end

    assign bus.coreEn      = core_en_s;
    assign bus.tick        = tick_s;
    assign bus.out         = out_r;
    assign bus.outFlag     = out_flag_r;
    assign bus.endFlag     = end_flag_r;
    assign bus.timeoutFlag = timeout_flag_r;
    assign bus.stepCount   = step_count_r;
    assign bus.busy        = active_s;
endmodule
